branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Fetch-side next-PC predictor for the pipeline: a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. Every cycle it turns the fetch PC into a predicted next PC (`pred_pc`), which travels with the instruction down to branch resolution. Branch resolution computes the true next PC and raises a cancel on mismatch, then returns the actual outcome on the update port to train the tables.

## Interface
Parameters:
- `ENTRIES`, 16: BTB entry count; power of two, 4..64. `IDX = log2(ENTRIES)`.
- `CNT_INIT`, 2'b10: counter value written on allocation (weakly taken).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `fetch_pc`  in  32  PC of the instruction being fetched this cycle.
- `pred_pc`  out  32  predicted next PC for `fetch_pc`; combinational from current table state.
- `pred_hit`  out  1  `fetch_pc` hit a valid entry.
- `upd_valid`  in  1  a branch-resolved record is presented this cycle.
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_is_branch`  in  1  resolved instruction is a jump or branch (jirl/b/bl/beq/bne/blt/bge/bltu/bgeu).
- `upd_taken`  in  1  actual next PC != `upd_pc`+4.
- `upd_target`  in  32  actual next PC when taken.
- `upd_mispred`  in  1  resolution cancelled this instruction (prediction was wrong).
- `mispred_cnt`  out  32  count of accepted updates with `upd_mispred`=1.
- `branch_cnt`  out  32  count of accepted updates with `upd_is_branch`=1.

## Operation
- Per entry: `valid`, `tag[31-IDX-2:0]`, `target[31:0]`, `cnt[1:0]`.
- Indexing: index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`; `pc[1:0]` are ignored.
- Lookup (combinational): hit = valid && tag match. `pred_pc` = target when hit && `cnt[1]`, otherwise `fetch_pc`+4 (mod 2^32, wraps from 0xFFFF_FFFC to 0).
- Update (when `upd_valid`), evaluated at index/tag of `upd_pc`:
  - Branch, hit, taken: `cnt` = min(cnt+1, 3); `target` = `upd_target`.
  - Branch, hit, not taken: `cnt` = max(cnt-1, 0); entry stays valid; target is unchanged.
  - Branch, miss, taken: allocate (overwriting any occupant): valid=1, tag, target=`upd_target`, cnt=`CNT_INIT`.
  - Branch, miss, not taken: no change.
  - Not a branch, hit (alias): valid=0.
  - Not a branch, miss: no change.
- Counters: `branch_cnt` += `upd_is_branch`; `mispred_cnt` += `upd_mispred`. Both are gated by `upd_valid` and wrap at 2^32.
- `upd_mispred` is statistical only; it never changes table state.

## Timing
- Lookup has zero latency. An update becomes visible to lookups from the cycle after the edge that writes it.
- Same-index update and lookup in one cycle: the lookup sees the pre-update state, with no bypass.
- One update per cycle. Back-to-back updates to the same index apply in order.
- Reset (asynchronous, any time, including mid-update): all `valid`=0, all `cnt`=2'b01, targets and tags=0, both counters=0.
  - Immediately after reset: `pred_hit`=0 and `pred_pc`=`fetch_pc`+4.
  - An update coincident with reset assertion is dropped.
- No stall input. The caller holds `fetch_pc` stable across stalls; the output follows `fetch_pc` combinationally.

## Test plan
- Reset then sweep: `fetch_pc`=0x1C00_0000 → `pred_pc`=0x1C00_0004, `pred_hit`=0. `fetch_pc`=0xFFFF_FFFC → `pred_pc`=0x0000_0000.
- Allocate/predict: update pc=0x1C00_0010, branch, taken, target=0x1C00_0100. Next cycle `fetch_pc`=0x1C00_0010 → `pred_hit`=1, `pred_pc`=0x1C00_0100. In the update cycle itself, lookup of the same PC still gives 0x1C00_0014.
- Saturation/hysteresis: after allocation (cnt=2), send 2 taken updates (cnt saturates at 3), then 1 not-taken → still predicts 0x1C00_0100. A second not-taken (cnt=1) → predicts 0x1C00_0014. Then 3 more not-taken → cnt stays 0 and entry stays valid (`pred_hit`=1).
- Aliasing, ENTRIES=16: with the entry allocated at 0x1C00_0010, allocate 0x1C00_0050 (same index 4, different tag). 0x1C00_0010 then misses. A non-branch update at 0x1C00_0050 invalidates the entry → `pred_hit`=0.
- Counters: 5 updates (3 branch, of which 2 mispred; 2 non-branch) plus 2 cycles with `upd_valid`=0 carrying mispred=1 → `branch_cnt`=3, `mispred_cnt`=2.
- Async reset mid-stream: assert `resetn`=0 between edges while entries are valid and an update is pending. Outputs clear without waiting for a clock edge; after release all lookups miss and both counters read 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Fetch-side next-PC predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained from branch resolution.
module branch_target_predictor #(
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CNT_INIT = 2'b10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] fetch_pc,
   output logic [31:0] pred_pc,
   output logic        pred_hit,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_branch,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispred,
   output logic [31:0] mispred_cnt,
   output logic [31:0] branch_cnt
);
   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = 30 - IDX;

   logic [ENTRIES-1:0] valid_reg;
   logic [TW-1:0]      tag_reg    [ENTRIES];
   logic [31:0]        target_reg [ENTRIES];
   logic [1:0]         cnt_reg    [ENTRIES];
   logic [31:0]        mispred_cnt_reg;
   logic [31:0]        branch_cnt_reg;

   logic [IDX-1:0] fetch_idx;
   logic [TW-1:0]  fetch_tag;
   logic [IDX-1:0] upd_idx;
   logic [TW-1:0]  upd_tag;
   logic           upd_hit;

   logic           valid_next;
   logic [TW-1:0]  tag_next;
   logic [31:0]    target_next;
   logic [1:0]     cnt_next;

   assign fetch_idx = fetch_pc[IDX+1:2];
   assign fetch_tag = fetch_pc[31:IDX+2];
   assign upd_idx   = upd_pc[IDX+1:2];
   assign upd_tag   = upd_pc[31:IDX+2];

   // Lookup reads current table state only; same-cycle updates are not bypassed.
   assign pred_hit = valid_reg[fetch_idx] && (tag_reg[fetch_idx] == fetch_tag);
   assign pred_pc  = (pred_hit && cnt_reg[fetch_idx][1]) ? target_reg[fetch_idx]
                                                         : fetch_pc + 32'd4;
   assign upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

   assign mispred_cnt = mispred_cnt_reg;
   assign branch_cnt  = branch_cnt_reg;

   always_comb begin
      valid_next  = valid_reg[upd_idx];
      tag_next    = tag_reg[upd_idx];
      target_next = target_reg[upd_idx];
      cnt_next    = cnt_reg[upd_idx];
      if (upd_is_branch) begin
         if (upd_hit) begin
            if (upd_taken) begin
               target_next = upd_target;
               if (cnt_reg[upd_idx] != 2'b11) cnt_next = cnt_reg[upd_idx] + 2'd1;
            end else if (cnt_reg[upd_idx] != 2'b00) begin
               cnt_next = cnt_reg[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_next  = 1'b1;
            tag_next    = upd_tag;
            target_next = upd_target;
            cnt_next    = CNT_INIT;
         end
      end else if (upd_hit) begin
         // A non-branch matching an entry means the entry aliased; drop it.
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_reg <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
            cnt_reg[i]    <= 2'b01;
         end
         mispred_cnt_reg <= '0;
         branch_cnt_reg  <= '0;
      end else if (upd_valid) begin
         valid_reg[upd_idx]  <= valid_next;
         tag_reg[upd_idx]    <= tag_next;
         target_reg[upd_idx] <= target_next;
         cnt_reg[upd_idx]    <= cnt_next;
         mispred_cnt_reg     <= mispred_cnt_reg + {31'd0, upd_mispred};
         branch_cnt_reg      <= branch_cnt_reg + {31'd0, upd_is_branch};
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed literal checks plus randomized
// traffic compared every cycle against a table-level model.
module tb_branch_target_predictor;
   localparam int ENTRIES = 16;
   localparam int IDX     = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] fetch_pc, pred_pc, upd_pc, upd_target, mispred_cnt, branch_cnt;
   logic        pred_hit, upd_valid, upd_is_branch, upd_taken, upd_mispred;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   int unsigned m_br, m_mp;
   bit          cmp_hit;
   int unsigned cmp_nxt;

   always #5 clk = ~clk;

   branch_target_predictor #(.ENTRIES(ENTRIES), .CNT_INIT(2'b10)) dut (
      .clk(clk), .resetn(resetn), .fetch_pc(fetch_pc), .pred_pc(pred_pc),
      .pred_hit(pred_hit), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispred(upd_mispred),
      .mispred_cnt(mispred_cnt), .branch_cnt(branch_cnt)
   );

   function automatic void m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      m_br = 0; m_mp = 0;
   endfunction

   function automatic void m_look(input int unsigned pc, output bit hit, output int unsigned nxt);
      int i = int'((pc >> 2) % ENTRIES);
      hit = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2)));
      nxt = (hit && m_cnt[i] >= 2) ? m_tgt[i] : pc + 4;
   endfunction

   function automatic void m_update(input int unsigned pc, input bit br, input bit tk,
                                    input int unsigned tgt, input bit mp);
      int i = int'((pc >> 2) % ENTRIES);
      bit hit = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2)));
      if (br) begin
         if (hit && tk) begin
            m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            m_tgt[i] = tgt;
         end else if (hit) begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
         end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = pc >> (IDX + 2); m_tgt[i] = tgt; m_cnt[i] = 2;
         end
      end else if (hit) begin
         m_valid[i] = 1'b0;
      end
      m_br += br;
      m_mp += mp;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         m_look(fetch_pc, cmp_hit, cmp_nxt);
         check("cyc_hit", {31'd0, pred_hit}, {31'd0, cmp_hit});
         check("cyc_pred_pc", pred_pc, cmp_nxt);
         check("cyc_branch_cnt", branch_cnt, m_br);
         check("cyc_mispred_cnt", mispred_cnt, m_mp);
      end
   end

   task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] pc,
                        input bit br, input bit tk, input logic [31:0] tgt, input bit mp);
      fetch_pc = fpc; upd_valid = uv; upd_pc = pc; upd_is_branch = br;
      upd_taken = tk; upd_target = tgt; upd_mispred = mp;
   endtask

   task automatic tick();
      @(posedge clk);
      if (resetn && upd_valid) begin
         m_update(upd_pc, upd_is_branch, upd_taken, upd_target, upd_mispred);
         $display("upd pc=%h br=%0d tk=%0d tgt=%h mp=%0d",
                  upd_pc, upd_is_branch, upd_taken, upd_target, upd_mispred);
      end
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input bit br, input bit tk,
                      input logic [31:0] tgt, input bit mp);
      drive(pc, 1'b1, pc, br, tk, tgt, mp);
      tick();
   endtask

   task automatic probe(input string name, input logic [31:0] fpc, input bit exp_hit,
                        input logic [31:0] exp_pc);
      drive(fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      check({name, "_hit"}, {31'd0, pred_hit}, {31'd0, exp_hit});
      check({name, "_pc"}, pred_pc, exp_pc);
   endtask

   function automatic logic [31:0] rand_pc();
      int unsigned bases [3] = '{32'h1C00_0000, 32'h1C00_1000, 32'hFFFF_FFC0};
      return bases[$urandom_range(0, 2)] + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
   endfunction

   initial begin
      resetn = 1'b0;
      drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      m_reset();
      #12 resetn = 1'b1;
      @(posedge clk); #1;

      // Reset state and PC+4 wrap
      probe("rst_a", 32'h1C00_0000, 1'b0, 32'h1C00_0004);
      probe("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
      check("rst_branch_cnt", branch_cnt, 32'd0);
      check("rst_mispred_cnt", mispred_cnt, 32'd0);
      chk_en = 1'b1;

      // Counters: 3 branch (2 mispred), 2 non-branch, then 2 idle with mispred high
      upd(32'h1C00_0400, 1'b1, 1'b0, 32'h0, 1'b1);
      upd(32'h1C00_0400, 1'b1, 1'b0, 32'h0, 1'b1);
      upd(32'h1C00_0404, 1'b1, 1'b0, 32'h0, 1'b0);
      upd(32'h1C00_0408, 1'b0, 1'b0, 32'h0, 1'b0);
      upd(32'h1C00_040C, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(32'h1C00_0400, 1'b0, 32'h1C00_0400, 1'b1, 1'b1, 32'h0, 1'b1); tick(); tick();
      check("cnt_branch", branch_cnt, 32'd3);
      check("cnt_mispred", mispred_cnt, 32'd2);

      // Allocate; same-cycle lookup still sees the old state
      drive(32'h1C00_0010, 1'b1, 32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 1'b0);
      #1;
      check("alloc_same_cycle_pc", pred_pc, 32'h1C00_0014);
      check("alloc_same_cycle_hit", {31'd0, pred_hit}, 32'd0);
      tick();
      probe("alloc", 32'h1C00_0010, 1'b1, 32'h1C00_0100);

      // Saturation and hysteresis
      upd(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 1'b0);
      upd(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 1'b0);
      upd(32'h1C00_0010, 1'b1, 1'b0, 32'h0, 1'b1);
      probe("sat_nt1", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      upd(32'h1C00_0010, 1'b1, 1'b0, 32'h0, 1'b1);
      probe("sat_nt2", 32'h1C00_0010, 1'b1, 32'h1C00_0014);
      for (int k = 0; k < 3; k++) upd(32'h1C00_0010, 1'b1, 1'b0, 32'h0, 1'b0);
      probe("sat_floor", 32'h1C00_0010, 1'b1, 32'h1C00_0014);

      // Aliasing at index 4
      upd(32'h1C00_0050, 1'b1, 1'b1, 32'h1C00_0200, 1'b0);
      probe("alias_old", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
      probe("alias_new", 32'h1C00_0050, 1'b1, 32'h1C00_0200);
      upd(32'h1C00_0050, 1'b0, 1'b0, 32'h0, 1'b0);
      probe("alias_inval", 32'h1C00_0050, 1'b0, 32'h1C00_0054);

      // Async reset mid-stream with a pending update
      upd(32'h1C00_0020, 1'b1, 1'b1, 32'h1C00_0300, 1'b0);
      drive(32'h1C00_0020, 1'b1, 32'h1C00_0030, 1'b1, 1'b1, 32'h1C00_0400, 1'b1);
      #1;
      check("prerst_hit", {31'd0, pred_hit}, 32'd1);
      check("prerst_pc", pred_pc, 32'h1C00_0300);
      #1 chk_en = 1'b0;
      resetn = 1'b0;
      #1;
      check("arst_hit", {31'd0, pred_hit}, 32'd0);
      check("arst_pc", pred_pc, 32'h1C00_0024);
      check("arst_branch_cnt", branch_cnt, 32'd0);
      check("arst_mispred_cnt", mispred_cnt, 32'd0);
      m_reset();
      tick();
      #1 resetn = 1'b1;
      probe("post_rst_pending", 32'h1C00_0030, 1'b0, 32'h1C00_0034);
      probe("post_rst_old", 32'h1C00_0020, 1'b0, 32'h1C00_0024);
      check("post_rst_branch_cnt", branch_cnt, 32'd0);
      check("post_rst_mispred_cnt", mispred_cnt, 32'd0);
      @(posedge clk); #1;
      chk_en = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] f, p;
         f = rand_pc();
         p = ($urandom_range(0, 3) == 0) ? f : rand_pc();
         drive(f, ($urandom_range(0, 9) < 7), p, ($urandom_range(0, 9) < 8),
               $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
         tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
